// File: rtl/vx_issue_scoreboard.sv
// Per-warp register scoreboard: tracks in-flight destination registers, raises the
// RAW/WAW issue stall and reports per-warp drain status. Optional macro: VX_SCOREBOARD_BYPASS_EN.
module vx_issue_scoreboard #(
  parameter int NW    = 8,
  parameter int NR    = 32,
  parameter int CNT_W = 6,
  localparam int WW   = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_issue_valid,
  input  logic [WW-1:0] in_issue_warp_num,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic          in_uses_rs1,
  input  logic          in_uses_rs2,
  input  logic [4:0]    in_rd,
  input  logic [1:0]    in_wb,
  input  logic          in_freeze,
  input  logic          in_wb_valid,
  input  logic [WW-1:0] in_wb_warp_num,
  input  logic [4:0]    in_wb_rd,
  output logic          out_fwd_stall,
  output logic [NW-1:0] out_warp_idle,
  output logic          out_err
);

  localparam logic [1:0] NO_WB = 2'b00;

  logic [NW-1:0][NR-1:0]    busy_q, busy_d;
  logic [NW-1:0][CNT_W-1:0] pend_cnt_q, pend_cnt_d;
  logic                     err_q, err_d;

  logic [NR-1:0] busy_row_s;
  logic          hazard_s;
  logic          wb_hit_s;
  logic          wb_clr_s;
  logic          wb_bad_s;
  logic          issue_acc_s;
  logic          issue_set_s;
  logic          cnt_err_s;

  // Hazard detection against the issuing warp's busy row.
  always_comb begin
    wb_hit_s   = busy_q[in_wb_warp_num][in_wb_rd];
    wb_clr_s   = in_wb_valid & (in_wb_rd != 5'd0) & wb_hit_s;
    wb_bad_s   = in_wb_valid & (in_wb_rd != 5'd0) & ~wb_hit_s;
    busy_row_s = busy_q[in_issue_warp_num];
`ifdef VX_SCOREBOARD_BYPASS_EN
    // A register retiring this cycle is forwarded by the D/E path, so it no longer blocks.
    if (wb_clr_s && (in_wb_warp_num == in_issue_warp_num)) begin
      busy_row_s[in_wb_rd] = 1'b0;
    end else begin
      busy_row_s = busy_row_s;
    end
`endif
    busy_row_s[0] = 1'b0;
    hazard_s      = (in_uses_rs1 & busy_row_s[in_rs1])
                  | (in_uses_rs2 & busy_row_s[in_rs2])
                  | ((in_wb != NO_WB) & busy_row_s[in_rd]);
    out_fwd_stall = in_issue_valid & hazard_s;
    issue_acc_s   = in_issue_valid & ~out_fwd_stall & ~in_freeze;
    issue_set_s   = issue_acc_s & (in_wb != NO_WB) & (in_rd != 5'd0);
  end

  // Next-state for busy bits, pending counters and the sticky error.
  always_comb begin
    busy_d     = busy_q;
    pend_cnt_d = pend_cnt_q;
    cnt_err_s  = 1'b0;
    if (wb_clr_s) begin
      busy_d[in_wb_warp_num][in_wb_rd] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    // Set after clear: the issuing instruction is younger than the one writing back.
    if (issue_set_s) begin
      busy_d[in_issue_warp_num][in_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    for (int i = 0; i < NW; i++) begin
      case ({issue_set_s && (in_issue_warp_num == WW'(i)),
             wb_clr_s && (in_wb_warp_num == WW'(i))})
        2'b10: begin
          if (pend_cnt_q[i] == {CNT_W{1'b1}}) begin
            cnt_err_s = 1'b1;
          end else begin
            pend_cnt_d[i] = pend_cnt_q[i] + CNT_W'(1);
          end
        end
        2'b01: begin
          if (pend_cnt_q[i] == {CNT_W{1'b0}}) begin
            cnt_err_s = 1'b1;
          end else begin
            pend_cnt_d[i] = pend_cnt_q[i] - CNT_W'(1);
          end
        end
        default: pend_cnt_d[i] = pend_cnt_q[i];
      endcase
    end
    err_d = err_q | wb_bad_s | cnt_err_s;
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      pend_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
      err_q      <= err_d;
    end
  end

  // Drain status straight from the registered counters.
  always_comb begin
    out_warp_idle = '0;
    for (int i = 0; i < NW; i++) begin
      out_warp_idle[i] = (pend_cnt_q[i] == {CNT_W{1'b0}});
    end
    out_err = err_q;
  end

endmodule

// File: tb/tb_vx_issue_scoreboard.sv
// Self-checking bench for vx_issue_scoreboard: directed scenarios plus randomized
// traffic against a behavioural model of pending registers per warp.
module tb_vx_issue_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_issue_valid;
  logic [2:0] in_issue_warp_num;
  logic [4:0] in_rs1, in_rs2, in_rd, in_wb_rd;
  logic       in_uses_rs1, in_uses_rs2;
  logic [1:0] in_wb;
  logic       in_freeze;
  logic       in_wb_valid;
  logic [2:0] in_wb_warp_num;
  logic       out_fwd_stall;
  logic [7:0] out_warp_idle;
  logic       out_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: set of pending registers per warp and sticky error.
  bit m_busy [8][32];
  bit m_err;

  vx_issue_scoreboard dut (
    .clk(clk), .reset(reset),
    .in_issue_valid(in_issue_valid), .in_issue_warp_num(in_issue_warp_num),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
    .in_rd(in_rd), .in_wb(in_wb), .in_freeze(in_freeze),
    .in_wb_valid(in_wb_valid), .in_wb_warp_num(in_wb_warp_num), .in_wb_rd(in_wb_rd),
    .out_fwd_stall(out_fwd_stall), .out_warp_idle(out_warp_idle), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic void model_clear();
    foreach (m_busy[w, r]) m_busy[w][r] = 1'b0;
    m_err = 1'b0;
  endfunction

  // Register r of warp w blocks issue this cycle?
  function automatic bit model_blocks(int w, int r);
    if (r == 0 || !m_busy[w][r]) return 1'b0;
`ifdef VX_SCOREBOARD_BYPASS_EN
    if (in_wb_valid && in_wb_warp_num == w && in_wb_rd == r) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic bit model_stall();
    int w = in_issue_warp_num;
    return in_issue_valid && ((in_uses_rs1 && model_blocks(w, in_rs1)) ||
                              (in_uses_rs2 && model_blocks(w, in_rs2)) ||
                              (in_wb != 2'd0 && model_blocks(w, in_rd)));
  endfunction

  function automatic logic [7:0] model_idle();
    logic [7:0] idle = 8'hFF;
    foreach (m_busy[w, r]) if (m_busy[w][r]) idle[w] = 1'b0;
    return idle;
  endfunction

  task automatic idle_inputs();
    in_issue_valid = 1'b0; in_issue_warp_num = 3'd0;
    in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0;
    in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0; in_wb = 2'd0; in_freeze = 1'b0;
    in_wb_valid = 1'b0; in_wb_warp_num = 3'd0; in_wb_rd = 5'd0;
  endtask

  task automatic issue(int w, int rs1, bit u1, int rs2, bit u2, int rd, int wb);
    in_issue_valid = 1'b1; in_issue_warp_num = 3'(w);
    in_rs1 = 5'(rs1); in_uses_rs1 = u1; in_rs2 = 5'(rs2); in_uses_rs2 = u2;
    in_rd = 5'(rd); in_wb = 2'(wb);
  endtask

  task automatic writeback(int w, int rd);
    in_wb_valid = 1'b1; in_wb_warp_num = 3'(w); in_wb_rd = 5'(rd);
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    bit acc, clr;
    acc = in_issue_valid && !model_stall() && !in_freeze;
    clr = in_wb_valid && in_wb_rd != 0 && m_busy[in_wb_warp_num][in_wb_rd];
    if (in_wb_valid && in_wb_rd != 0 && !clr) m_err = 1'b1;
    if (clr) m_busy[in_wb_warp_num][in_wb_rd] = 1'b0;
    if (acc && in_wb != 2'd0 && in_rd != 0) m_busy[in_issue_warp_num][in_rd] = 1'b1;
    if (reset) model_clear();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    issue(0, 3, 1, 0, 0, 0, 0);
    #1;
    n_cmp++; if (out_fwd_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", out_fwd_stall); end
    n_cmp++; if (out_warp_idle !== 8'hFF) begin n_fail++; $display("FAIL reset_idle: got %h want ff", out_warp_idle); end
    n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", out_err); end
    tick();
  endtask

  task automatic test_raw_waw();
    issue(2, 0, 0, 0, 0, 5, 1);
    #1;
    n_cmp++; if (out_fwd_stall !== 1'b0) begin n_fail++; $display("FAIL first_issue_stall: got %b want 0", out_fwd_stall); end
    tick();
    issue(2, 5, 1, 0, 0, 0, 0);
    #1;
    n_cmp++; if (out_fwd_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b want 1", out_fwd_stall); end
    n_cmp++; if (out_warp_idle[2] !== 1'b0) begin n_fail++; $display("FAIL idle2_busy: got %b want 0", out_warp_idle[2]); end
    issue(1, 5, 1, 0, 0, 0, 0);
    #1;
    n_cmp++; if (out_fwd_stall !== 1'b0) begin n_fail++; $display("FAIL other_warp_stall: got %b want 0", out_fwd_stall); end
    issue(2, 0, 0, 0, 0, 5, 2);
    #1;
    n_cmp++; if (out_fwd_stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall: got %b want 1", out_fwd_stall); end
    tick();
  endtask

  task automatic test_wb_bypass();
    bit exp_stall;
`ifdef VX_SCOREBOARD_BYPASS_EN
    exp_stall = 1'b0;
`else
    exp_stall = 1'b1;
`endif
    issue(2, 0, 0, 5, 1, 0, 0);
    writeback(2, 5);
    #1;
    n_cmp++; if (out_fwd_stall !== exp_stall) begin n_fail++; $display("FAIL wb_cycle_stall: got %b want %b", out_fwd_stall, exp_stall); end
    tick();
    n_cmp++; if (out_warp_idle[2] !== 1'b1) begin n_fail++; $display("FAIL idle2_after_wb: got %b want 1", out_warp_idle[2]); end
    issue(2, 0, 0, 5, 1, 0, 0);
    #1;
    n_cmp++; if (out_fwd_stall !== 1'b0) begin n_fail++; $display("FAIL after_wb_stall: got %b want 0", out_fwd_stall); end
    tick();
  endtask

  task automatic test_rd_zero();
    issue(0, 0, 0, 0, 0, 0, 1);
    tick();
    n_cmp++; if (out_warp_idle[0] !== 1'b1) begin n_fail++; $display("FAIL rd0_idle: got %b want 1", out_warp_idle[0]); end
    issue(0, 0, 1, 0, 0, 0, 1);
    #1;
    n_cmp++; if (out_fwd_stall !== 1'b0) begin n_fail++; $display("FAIL rd0_stall: got %b want 0", out_fwd_stall); end
    idle_inputs();
    writeback(0, 0);
    tick();
    n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL rd0_wb_err: got %b want 0", out_err); end
  endtask

  task automatic test_err();
    writeback(3, 7);
    #1;
    n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL err_early: got %b want 0", out_err); end
    tick();
    n_cmp++; if (out_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", out_err); end
    tick();
    tick();
    n_cmp++; if (out_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", out_err); end
  endtask

  task automatic test_freeze_reset();
    do_reset();
    n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", out_err); end
    issue(4, 0, 0, 0, 0, 8, 1);
    tick();
    issue(4, 0, 0, 0, 0, 9, 1);
    in_freeze = 1'b1;
    writeback(4, 8);
    #1;
    n_cmp++; if (out_fwd_stall !== 1'b0) begin n_fail++; $display("FAIL freeze_stall: got %b want 0", out_fwd_stall); end
    tick();
    n_cmp++; if (out_warp_idle[4] !== 1'b1) begin n_fail++; $display("FAIL freeze_idle4: got %b want 1", out_warp_idle[4]); end
    issue(4, 9, 1, 8, 1, 0, 0);
    #1;
    n_cmp++; if (out_fwd_stall !== 1'b0) begin n_fail++; $display("FAIL freeze_no_set: got %b want 0", out_fwd_stall); end
    issue(4, 0, 0, 0, 0, 9, 1);
    tick();
    issue(6, 0, 0, 0, 0, 3, 1);
    tick();
    n_cmp++; if (out_warp_idle !== 8'hAF) begin n_fail++; $display("FAIL pre_reset_idle: got %h want af", out_warp_idle); end
    reset = 1'b1;
    model_clear();
    issue(4, 9, 1, 0, 0, 0, 0);
    #1;
    n_cmp++; if (out_warp_idle !== 8'hFF) begin n_fail++; $display("FAIL midreset_idle: got %h want ff", out_warp_idle); end
    n_cmp++; if (out_fwd_stall !== 1'b0) begin n_fail++; $display("FAIL midreset_stall: got %b want 0", out_fwd_stall); end
    tick();
    reset = 1'b0;
    writeback(6, 3);
    tick();
    n_cmp++; if (out_err !== 1'b1) begin n_fail++; $display("FAIL post_reset_wb_err: got %b want 1", out_err); end
    do_reset();
  endtask

  task automatic test_random();
    bit exp_stall;
    for (int c = 0; c < 400; c++) begin
      issue($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 1),
            $urandom_range(0, 5), $urandom_range(0, 1), $urandom_range(0, 5), $urandom_range(0, 3));
      in_issue_valid = ($urandom_range(0, 3) != 0);
      in_freeze = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) begin
        int w = $urandom_range(0, 3);
        int r = $urandom_range(0, 5);
        if (m_busy[w][r] || r == 0 || $urandom_range(0, 49) == 0) writeback(w, r);
      end
      #1;
      exp_stall = model_stall();
      n_cmp++; if (out_fwd_stall !== exp_stall) begin n_fail++; $display("FAIL rand_stall c=%0d: got %b want %b", c, out_fwd_stall, exp_stall); end
      tick();
      n_cmp++; if (out_warp_idle !== model_idle()) begin n_fail++; $display("FAIL rand_idle c=%0d: got %h want %h", c, out_warp_idle, model_idle()); end
      n_cmp++; if (out_err !== m_err) begin n_fail++; $display("FAIL rand_err c=%0d: got %b want %b", c, out_err, m_err); end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_clear();
    #1;
    test_reset();
    test_raw_waw();
    test_wb_bypass();
    test_rd_zero();
    test_err();
    test_freeze_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
